// File: rtl/data_memory_seq.sv
// Byte-addressable little-endian data memory with a valid/ready request/response handshake.
// A single-port byte array is walked one byte per cycle, so a word access takes BYTES cycles.
module data_memory_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_BYTES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MAW   = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg;
    logic [CW-1:0]         last_reg;
    logic [MAW-1:0]        addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  write_reg;
    logic [1:0]            size_reg;
    logic [DATA_WIDTH-1:0] asm_reg, asm_next;
    logic [DATA_WIDTH-1:0] load_result;

    logic [7:0]            mem [DEPTH_BYTES];
    logic [MAW-1:0]        byte_addr;
    logic [7:0]            rd_byte;
    logic [7:0]            wr_byte;
    logic                  accept;
    logic                  is_last;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid && req_ready;
    assign is_last   = (cnt_reg == last_reg);
    // Modulo DEPTH_BYTES falls out of the MAW-bit sum, so word accesses wrap to byte 0.
    assign byte_addr = addr_reg + MAW'(cnt_reg);
    assign rd_byte   = mem[byte_addr];
    assign wr_byte   = wdata_reg[{cnt_reg, 3'b000} +: 8];

    generate
        if (ADDR_WIDTH > MAW) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:MAW];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (req_size == 2'b11) ? ERR : BUSY;
                end
            end
            BUSY: begin
                if (is_last) begin
                    state_next = IDLE;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The byte being read this cycle is merged in before formatting, so the last byte
    // lands in resp_rdata on the same edge that ends BUSY.
    always_comb begin
        asm_next = asm_reg;
        asm_next[{cnt_reg, 3'b000} +: 8] = rd_byte;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_fmt
            if (gi < 8) begin : g_low
                assign load_result[gi] = asm_next[gi];
            end else begin : g_high
                assign load_result[gi] = (size_reg == 2'b00) ? asm_next[gi]
                                       : (size_reg == 2'b10) ? asm_next[7]
                                       : 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            last_reg   <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            write_reg  <= 1'b0;
            size_reg   <= 2'b00;
            asm_reg    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg   <= '0;
                        last_reg  <= (req_size == 2'b00) ? LAST_WORD : '0;
                        addr_reg  <= req_addr[MAW-1:0];
                        wdata_reg <= req_wdata;
                        write_reg <= req_write;
                        size_reg  <= req_size;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (!write_reg) begin
                        asm_reg <= asm_next;
                    end
                    if (is_last) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        if (!write_reg) begin
                            resp_rdata <= load_result;
                        end
                    end
                end
                ERR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    // No reset on the array; an aborted store stops because reset drops the FSM out of BUSY.
    always_ff @(posedge clk) begin
        if (state_reg == BUSY && write_reg) begin
            mem[byte_addr] <= wr_byte;
        end
    end

endmodule
